inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter total_cycle, default 8, number of Q vectors per pass (legal 1..16).
REQ-002 SHALL have parameter col, default 8, number of K vectors / dot-product columns (legal 1..16).
REQ-003 SHALL have parameter handshake_cycle, default 10, per-row divide wait length (legal 1..255).
REQ-004 SHALL have parameter gap_cycle, default 10, idle cycles inserted between phases (legal 0..255).
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  begin a full pass; sampled only in IDLE.
REQ-009 hold  input  1  defers entry into the next phase while high.
REQ-010 div_ack  input  1  divide-handshake acknowledge from partner core.
REQ-011 inst  output  19  registered core instruction: [18] div, [17] acc, [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
REQ-012 busy  output  1  high from the first non-IDLE cycle through DONE.
REQ-013 done  output  1  one-cycle pulse in DONE.
REQ-014 phase  output  4  current state code.
REQ-015 div_timeout  output  1  sticky flag; cleared on accepted start.

Function
REQ-016 SHALL use states and codes IDLE=0, QWR=1, KWR=2, LOAD=3, EXEC=4, OFIFO=5, ACC=6, DIV=7, WAIT=8, DONE=9.
REQ-017 SHALL follow the order IDLE->QWR->KWR->LOAD->WAIT->EXEC->WAIT->OFIFO->ACC->WAIT->DIV->DONE->IDLE; WAIT lasts gap_cycle cycles and is skipped when gap_cycle=0.
REQ-018 On start=1 in IDLE, SHALL present the first QWR word on inst at the next rising edge, with busy rising on that same edge.
REQ-019 QWR SHALL last total_cycle cycles with qmem_wr=1 and qkmem_add=0..total_cycle-1; KWR SHALL last col cycles with kmem_wr=1 and qkmem_add=0..col-1.
REQ-020 LOAD SHALL last col+2 cycles with load=1 throughout; kmem_rd=1 only in cycles 1..col; qkmem_add=k-1 in cycle k for 1<=k<=col, else 0.
REQ-021 EXEC SHALL last total_cycle cycles with execute=1, qmem_rd=1 and qkmem_add=0..total_cycle-1.
REQ-022 OFIFO SHALL last total_cycle cycles with ofifo_rd=1, pmem_wr=1 and pmem_add=0..total_cycle-1; ACC SHALL do the same with pmem_rd=1 and acc=1.
REQ-023 DIV SHALL hold div=1 throughout; for each row r: one issue cycle with pmem_rd=1 and pmem_add=r, then a wait (REQ-031), then row r+1.
REQ-024 All inst fields not listed for a state SHALL be 0; in IDLE, WAIT and DONE inst SHALL be all-zero.
REQ-025 Address counters SHALL be 4-bit and SHALL never wrap within a phase (legal parameters guarantee this).
REQ-026 While hold=1 at a phase's final cycle, SHALL remain in a zero-inst stall and enter the next phase on the first cycle after hold falls; hold SHALL NOT interrupt a phase in progress.
REQ-027 start while busy SHALL be ignored; start and hold both high in IDLE SHALL defer QWR until hold falls.

Reset
REQ-028 Reset assertion at any time, including mid-phase, SHALL immediately force IDLE, inst=0, busy=0, done=0, phase=0, div_timeout=0 and all counters to 0.
REQ-029 After deassertion, SHALL wait in IDLE for a new start; no partial pass is resumed.

Configuration
REQ-030 Macro INST_SEQ_DIV_ACK_EN SHALL select the DIV wait mode.
REQ-031 Without the macro, each row wait SHALL be exactly handshake_cycle cycles and div_ack is ignored; with it, the wait SHALL end on the cycle after div_ack=1, or after handshake_cycle cycles without ack, in which case div_timeout SHALL set and the sequencer SHALL proceed.

Verification
REQ-032 Defaults, fixed mode, single start pulse, no hold -> busy high exactly 169 cycles, done pulse once, phase sequence per REQ-017.
REQ-033 Defaults, LOAD phase -> 10 cycles with load=1; kmem_rd high in cycles 1..8 with qkmem_add 0..7; cycle 9 has load=1, kmem_rd=0.
REQ-034 hold=1 from the final EXEC cycle for 5 cycles -> EXEC completes intact, 5 extra zero cycles, then WAIT; total busy 174.
REQ-035 Reset pulled low mid-OFIFO at pmem_add=3 -> inst=0, busy=0 asynchronously; a new start reruns from QWR address 0.
REQ-036 With INST_SEQ_DIV_ACK_EN, div_ack asserted 2 cycles after each issue -> each row takes 4 cycles, div_timeout=0; with div_ack never asserted -> each row takes 11 cycles and div_timeout=1 after row 0.
REQ-037 Parameters total_cycle=16, col=16 -> qkmem_add reaches 15 in QWR, KWR and EXEC without wrap; start during busy has no effect.

Source files
------------

// File: rtl/inst_sequencer.sv
`default_nettype none
// inst_sequencer: steps the attention core through QWR..DIV passes, one registered instruction word per cycle.
// Build option: define INST_SEQ_DIV_ACK_EN to end each divide wait on div_ack (with timeout) instead of a fixed count.
module inst_sequencer #(
    parameter int total_cycle     = 8,
    parameter int col             = 8,
    parameter int handshake_cycle = 10,
    parameter int gap_cycle       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    input  logic        div_ack,
    output logic [18:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  phase,
    output logic        div_timeout
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0, S_QWR  = 4'd1, S_KWR = 4'd2, S_LOAD = 4'd3, S_EXEC = 4'd4,
        S_OFIFO = 4'd5, S_ACC  = 4'd6, S_DIV = 4'd7, S_WAIT = 4'd8, S_DONE = 4'd9
    } state_t;

    localparam logic [7:0] TC_LAST   = 8'(total_cycle - 1);
    localparam logic [7:0] COL_LAST  = 8'(col - 1);
    localparam logic [7:0] COL_N     = 8'(col);
    localparam logic [7:0] LOAD_LAST = 8'(col + 1);
    localparam logic [7:0] GAP_LAST  = 8'((gap_cycle > 0) ? gap_cycle - 1 : 0);
    localparam logic [7:0] HS_LAST   = 8'(handshake_cycle - 1);
    localparam logic [3:0] ROW_LAST  = 4'(total_cycle - 1);
    localparam bit         GAP_EN    = (gap_cycle > 0);

    state_t      state_q, state_d, pend_q, pend_d, wnext_q, wnext_d, w_nxt;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  row_q, row_d;
    logic        dwait_q, dwait_d, acked_q, acked_d, stall_q, stall_d;
    logic        spend_q, spend_d, tmo_q, tmo_d;
    logic [18:0] inst_q, w_inst_d;
    logic        busy_q, done_q;
    logic [3:0]  phase_q;
    logic        w_last, w_row_end, w_tmo_hit, w_ack_seen;

`ifdef INST_SEQ_DIV_ACK_EN
    assign w_row_end  = acked_q || (cnt_q == HS_LAST);
    assign w_tmo_hit  = (cnt_q == HS_LAST) && !acked_q && !div_ack;
    assign w_ack_seen = div_ack;
`else
    logic unused_div_ack;
    assign unused_div_ack = div_ack;
    assign w_row_end  = (cnt_q == HS_LAST);
    assign w_tmo_hit  = 1'b0;
    assign w_ack_seen = 1'b0;
`endif

    function automatic state_t after_phase(input state_t s);
        case (s)
            S_QWR:   after_phase = S_KWR;
            S_KWR:   after_phase = S_LOAD;
            S_LOAD:  after_phase = S_EXEC;
            S_EXEC:  after_phase = S_OFIFO;
            S_OFIFO: after_phase = S_ACC;
            S_ACC:   after_phase = S_DIV;
            S_DIV:   after_phase = S_DONE;
            default: after_phase = S_IDLE;
        endcase
    endfunction

    function automatic logic [18:0] decode(input state_t s, input logic [7:0] c,
                                           input logic [3:0] r, input logic dw);
        logic [18:0] w;
        w = '0;
        case (s)
            S_QWR:   begin w[4] = 1'b1; w[15:12] = c[3:0]; end
            S_KWR:   begin w[2] = 1'b1; w[15:12] = c[3:0]; end
            S_LOAD: begin
                w[6] = 1'b1;
                if (c >= 8'd1 && c <= COL_N) begin
                    w[3]     = 1'b1;
                    w[15:12] = 4'(c - 8'd1);
                end
            end
            S_EXEC:  begin w[7] = 1'b1; w[5] = 1'b1; w[15:12] = c[3:0]; end
            S_OFIFO: begin w[16] = 1'b1; w[0] = 1'b1; w[11:8] = c[3:0]; end
            S_ACC:   begin w[17] = 1'b1; w[1] = 1'b1; w[11:8] = c[3:0]; end
            S_DIV: begin
                w[18] = 1'b1;
                if (!dw) begin
                    w[1]    = 1'b1;
                    w[11:8] = r;
                end
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        dwait_d = dwait_q;
        acked_d = acked_q;
        stall_d = stall_q;
        pend_d  = pend_q;
        wnext_d = wnext_q;
        spend_d = spend_q;
        tmo_d   = tmo_q;
        w_last  = 1'b0;
        w_nxt   = S_IDLE;

        if (stall_q) begin
            if (!hold) begin
                state_d = pend_q;
                stall_d = 1'b0;
                cnt_d   = '0;
                row_d   = '0;
                dwait_d = 1'b0;
                acked_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start || spend_q) begin
                        if (hold) begin
                            spend_d = 1'b1;
                        end else begin
                            state_d = S_QWR;
                            spend_d = 1'b0;
                            tmo_d   = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                end
                S_QWR, S_EXEC, S_OFIFO, S_ACC: begin
                    w_last = (cnt_q == TC_LAST);
                    cnt_d  = cnt_q + 8'd1;
                end
                S_KWR:  begin w_last = (cnt_q == COL_LAST);  cnt_d = cnt_q + 8'd1; end
                S_LOAD: begin w_last = (cnt_q == LOAD_LAST); cnt_d = cnt_q + 8'd1; end
                S_WAIT: begin w_last = (cnt_q == GAP_LAST);  cnt_d = cnt_q + 8'd1; end
                S_DIV: begin
                    if (!dwait_q) begin
                        dwait_d = 1'b1;
                        cnt_d   = '0;
                        acked_d = 1'b0;
                    end else if (w_row_end) begin
                        if (w_tmo_hit) tmo_d = 1'b1;
                        if (row_q == ROW_LAST) begin
                            w_last = 1'b1;
                        end else begin
                            row_d   = row_q + 4'd1;
                            dwait_d = 1'b0;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (w_ack_seen) acked_d = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
                default: state_d = S_IDLE;
            endcase

            // Phase boundary: pick the successor, or park in a zero-inst stall while hold is high.
            if (w_last) begin
                if (state_q == S_WAIT) begin
                    w_nxt = wnext_q;
                end else if (GAP_EN && (state_q == S_LOAD || state_q == S_EXEC || state_q == S_ACC)) begin
                    w_nxt   = S_WAIT;
                    wnext_d = after_phase(state_q);
                end else begin
                    w_nxt = after_phase(state_q);
                end
                if (hold) begin
                    stall_d = 1'b1;
                    pend_d  = w_nxt;
                end else begin
                    state_d = w_nxt;
                    cnt_d   = '0;
                    row_d   = '0;
                    dwait_d = 1'b0;
                    acked_d = 1'b0;
                end
            end
        end
    end

    assign w_inst_d = stall_d ? 19'd0 : decode(state_d, cnt_d, row_d, dwait_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= S_IDLE;
            wnext_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            dwait_q <= 1'b0;
            acked_q <= 1'b0;
            stall_q <= 1'b0;
            spend_q <= 1'b0;
            tmo_q   <= 1'b0;
            inst_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wnext_q <= wnext_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            dwait_q <= dwait_d;
            acked_q <= acked_d;
            stall_q <= stall_d;
            spend_q <= spend_d;
            tmo_q   <= tmo_d;
            inst_q  <= w_inst_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE) && !stall_d;
            phase_q <= state_d;
        end
    end

    assign inst        = inst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign phase       = phase_q;
    assign div_timeout = tmo_q;
endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// Scoreboard bench for inst_sequencer: a default instance and a 16x16 no-gap instance.
module tb_inst_sequencer;
    localparam int F_DIV = 1 << 18, F_ACC = 1 << 17, F_OF = 1 << 16, F_EXE = 1 << 7;
    localparam int F_LD  = 1 << 6,  F_QRD = 1 << 5,  F_QWR = 1 << 4, F_KRD = 1 << 3;
    localparam int F_KWR = 1 << 2,  F_PRD = 1 << 1,  F_PWR = 1 << 0;
`ifdef INST_SEQ_DIV_ACK_EN
    localparam bit EXP_TMO = 1'b1;
`else
    localparam bit EXP_TMO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, div_ack;
    logic        start_a, hold_a, start_b, hold_b;
    logic [18:0] inst_a, inst_b;
    logic        busy_a, busy_b, done_a, done_b, tmo_a, tmo_b;
    logic [3:0]  phase_a, phase_b;
    bit          sel_b;

    inst_sequencer dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .hold(hold_a), .div_ack(div_ack),
        .inst(inst_a), .busy(busy_a), .done(done_a), .phase(phase_a), .div_timeout(tmo_a)
    );

    inst_sequencer #(.total_cycle(16), .col(16), .handshake_cycle(3), .gap_cycle(0)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .hold(hold_b), .div_ack(div_ack),
        .inst(inst_b), .busy(busy_b), .done(done_b), .phase(phase_b), .div_timeout(tmo_b)
    );

    wire [18:0] obs_inst  = sel_b ? inst_b  : inst_a;
    wire        obs_busy  = sel_b ? busy_b  : busy_a;
    wire        obs_done  = sel_b ? done_b  : done_a;
    wire [3:0]  obs_phase = sel_b ? phase_b : phase_a;
    wire        obs_tmo   = sel_b ? tmo_b   : tmo_a;

    typedef struct {
        logic [18:0] inst;
        logic [3:0]  phase;
        logic        busy, done, chk_phase, hold_drv, start_drv, rst_here;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int w, input int ph, input bit h);
        exp_t e;
        e.inst      = 19'(w);
        e.phase     = (ph < 0) ? 4'd0 : 4'(ph);
        e.chk_phase = (ph >= 0);
        e.busy      = (ph != 0);
        e.done      = (ph == 9);
        e.hold_drv  = h;
        e.start_drv = 1'b0;
        e.rst_here  = 1'b0;
        sb.push_back(e);
    endtask

    // Expected per-cycle words for one pass, written straight from the phase table.
    task automatic build(input int tc, input int cl, input int hs, input int gp, input int hold_n);
        for (int i = 0; i < tc; i++) push(F_QWR | (i << 12), 1, 0);
        for (int i = 0; i < cl; i++) push(F_KWR | (i << 12), 2, 0);
        for (int k = 0; k <= cl + 1; k++)
            push(F_LD | ((k >= 1 && k <= cl) ? (F_KRD | ((k - 1) << 12)) : 0), 3, 0);
        for (int i = 0; i < gp; i++) push(0, 8, 0);
        for (int i = 0; i < tc; i++) push(F_EXE | F_QRD | (i << 12), 4, (hold_n > 0) && (i == tc - 1));
        for (int s = 0; s < hold_n; s++) push(0, -1, s < hold_n - 1);
        for (int i = 0; i < gp; i++) push(0, 8, 0);
        for (int i = 0; i < tc; i++) push(F_OF | F_PWR | (i << 8), 5, 0);
        for (int i = 0; i < tc; i++) push(F_ACC | F_PRD | (i << 8), 6, 0);
        for (int i = 0; i < gp; i++) push(0, 8, 0);
        for (int r = 0; r < tc; r++) begin
            push(F_DIV | F_PRD | (r << 8), 7, 0);
            for (int w = 0; w < hs; w++) push(F_DIV, 7, 0);
        end
        push(0, 9, 0);
        push(0, 0, 0);
    endtask

    task automatic drive(input bit s, input bit h);
        if (sel_b) begin start_b = s; hold_b = h; end
        else       begin start_a = s; hold_a = h; end
    endtask

    task automatic run_pass(input string tag, input bit pre_hold, input int exp_busy);
        int   busy_n = 0;
        int   done_n = 0;
        int   idx    = 0;
        bit   aborted = 0;
        exp_t e;
        @(negedge clk);
        drive(1'b1, pre_hold);
        if (pre_hold) begin
            repeat (3) begin
                @(posedge clk); #1;
                check({tag, "_defer"}, {obs_busy, obs_phase, obs_inst}, 0);
            end
            drive(1'b1, 1'b0);
        end
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            check($sformatf("%s[%0d]", tag, idx),
                  {obs_busy, obs_done, (e.chk_phase ? obs_phase : 4'd0), obs_inst},
                  {e.busy, e.done, e.phase, e.inst});
            busy_n += int'(obs_busy);
            done_n += int'(obs_done);
            drive(e.start_drv, e.hold_drv);
            if (e.rst_here) begin
                #2 rst_n = 1'b0;
                #1 check({tag, "_rst_async"}, {obs_inst, obs_busy, obs_done, obs_phase, obs_tmo}, 0);
                sb.delete();
                aborted = 1;
                @(negedge clk) rst_n = 1'b1;
            end
            idx++;
        end
        if (!aborted) begin
            check({tag, "_busy_cycles"}, busy_n, exp_busy);
            check({tag, "_done_pulses"}, done_n, 1);
            check({tag, "_div_timeout"}, obs_tmo, EXP_TMO);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        div_ack = 1'b0;
        start_a = 1'b0; hold_a = 1'b0;
        start_b = 1'b0; hold_b = 1'b0;
        sel_b   = 0;
        #3;
        check("reset_a", {inst_a, busy_a, done_a, phase_a, tmo_a}, 0);
        check("reset_b", {inst_b, busy_b, done_b, phase_b, tmo_b}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_no_start", {busy_a, phase_a, inst_a}, 0);

        build(8, 8, 10, 10, 0);
        run_pass("plain", 0, 169);

        build(8, 8, 10, 10, 5);
        run_pass("hold5", 0, 174);

        build(8, 8, 10, 10, 0);
        foreach (sb[i]) if (sb[i].phase == 4'd5 && sb[i].inst == 19'(F_OF | F_PWR | (3 << 8))) sb[i].rst_here = 1'b1;
        run_pass("rst_ofifo", 0, 0);
        build(8, 8, 10, 10, 0);
        run_pass("rerun", 0, 169);

        sel_b = 1;
        build(16, 16, 3, 0, 0);
        sb[20].start_drv = 1'b1;
        sb[150].start_drv = 1'b1;
        run_pass("p16", 1, 163);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
